fetch_sequencer: RTL and testbench

- Owns and sequences the program counter for the fetch stage. The fetch stage keeps only its instruction memory and read port.
- Selects each cycle between increment, hold (stall), branch redirect and interrupt-vector fetch.
- Loads interrupt handler addresses from the reserved low region of instruction memory (entries 0..2^5-1).
- Drives the instruction-memory address every cycle and reports whether the fetched word is valid.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_sequencer_pc_next_mux.sv | 25 ++
 rtl/fetch_sequencer.sv | 70 +++++++
 tb/tb_fetch_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch/decode constants and the PC sequencer state encoding
package fetch_pkg;
  localparam int PC_WIDTH = 32;
  localparam int INSTR_WIDTH = 16;
  localparam int INT_IDX_W = 4;
  localparam logic [31:0] RESET_PC = 32'd32;
  localparam logic [31:0] VEC_BASE = 32'd0;
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    VEC_HI = 2'd1,
    VEC_LO = 2'd2
  } state_e;
endpackage

// File: rtl/fetch_sequencer_pc_next_mux.sv
// pc_next_mux: next-PC priority select (reset, vector load, branch, stall, increment)
module pc_next_mux #(
  parameter int PC_WIDTH = fetch_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(fetch_pkg::RESET_PC)
) (
  input  logic                  reset,
  input  fetch_pkg::state_e     state,
  input  logic                  take,
  input  logic                  branch_taken,
  input  logic [PC_WIDTH-1:0]   branch_target,
  input  logic                  stall,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic [PC_WIDTH-1:0]   vec_pc,
  output logic [PC_WIDTH-1:0]   pc_d
);
  import fetch_pkg::*;
  // An accepted interrupt parks the PC; the handler address arrives in VEC_LO.
  always_comb begin
    pc_d = !reset ? RESET_PC :
           state == VEC_LO ? vec_pc :
           (state != RUN || take) ? pc :
           branch_taken ? branch_target :
           stall ? pc : pc + PC_WIDTH'(1);
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC; sequences increment/stall/branch and
// two-word interrupt vector loads from the low region of instruction memory.
module fetch_sequencer #(
  parameter int PC_WIDTH = fetch_pkg::PC_WIDTH,
  parameter int INSTR_WIDTH = fetch_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(fetch_pkg::RESET_PC),
  parameter logic [PC_WIDTH-1:0] VEC_BASE = PC_WIDTH'(fetch_pkg::VEC_BASE),
  parameter int INT_IDX_W = fetch_pkg::INT_IDX_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   int_req,
  input  logic [INT_IDX_W-1:0]   int_index,
  input  logic                   int_done,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   fetch_valid,
  output logic                   int_ack,
  output logic [PC_WIDTH-1:0]    saved_pc,
  output logic                   busy
);
  import fetch_pkg::*;
  state_e                  state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d, saved_pc_q, saved_pc_d, vec_ptr_q, vec_ptr_d, vec_pc;
  logic [INSTR_WIDTH-1:0]  vec_hi_q, vec_hi_d;
  logic                    int_en_q, int_en_d, int_ack_q, int_ack_d, take;
  pc_next_mux #(.PC_WIDTH(PC_WIDTH), .RESET_PC(RESET_PC)) u_mux (
    .reset(reset), .state(state_q), .take(take), .branch_taken(branch_taken),
    .branch_target(branch_target), .stall(stall), .pc(pc_q), .vec_pc(vec_pc), .pc_d(pc_d)
  );
  always_comb begin
    take = state_q == RUN && int_req && int_en_q;
    state_d = take ? VEC_HI : state_q == VEC_HI ? VEC_LO : RUN;
    saved_pc_d = take ? (branch_taken ? branch_target : pc_q) : saved_pc_q;
    vec_ptr_d = take ? VEC_BASE + (PC_WIDTH'(int_index) << 1) : vec_ptr_q;
    vec_hi_d = state_q == VEC_HI ? imem_data : vec_hi_q;
    int_en_d = take ? 1'b0 : int_done ? 1'b1 : int_en_q;
    int_ack_d = take;
    vec_pc = PC_WIDTH'({vec_hi_q, imem_data});
  end
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    if (!reset) begin
      state_q <= RUN;
      int_en_q <= 1'b1;
      saved_pc_q <= '0;
      vec_hi_q <= '0;
      vec_ptr_q <= '0;
      int_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      int_en_q <= int_en_d;
      saved_pc_q <= saved_pc_d;
      vec_hi_q <= vec_hi_d;
      vec_ptr_q <= vec_ptr_d;
      int_ack_q <= int_ack_d;
    end
  end
  assign imem_addr = state_q == VEC_HI ? vec_ptr_q :
                     state_q == VEC_LO ? vec_ptr_q + PC_WIDTH'(1) : pc_q;
  assign pc_out = pc_q;
  assign fetch_valid = reset && state_q == RUN && !stall && !take;
  assign int_ack = int_ack_q;
  assign saved_pc = saved_pc_q;
  assign busy = state_q != RUN;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of PC sequencing, stall, branch, vector fetch and reset.
module tb_fetch_sequencer;
  logic        clk = 0, reset = 0, stall = 0, branch_taken = 0, int_req = 0, int_done = 0;
  logic [31:0] branch_target = 0;
  logic [3:0]  int_index = 0;
  logic [15:0] imem_data;
  logic [31:0] imem_addr, pc_out, saved_pc;
  logic        fetch_valid, int_ack, busy;
  logic [15:0] mem [0:1023];
  int vectors = 0, errs = 0;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .int_req(int_req), .int_index(int_index),
    .int_done(int_done), .imem_data(imem_data), .imem_addr(imem_addr), .pc_out(pc_out),
    .fetch_valid(fetch_valid), .int_ack(int_ack), .saved_pc(saved_pc), .busy(busy)
  );

  always #5 clk = ~clk;
  assign imem_data = imem_addr < 32'd1024 ? mem[imem_addr[9:0]] : 16'h0;

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i ^ 16'h5a5a);
    mem[6] = 16'h0000;
    mem[7] = 16'h0200;
    // reset held two cycles
    tick();
    chk("rst_pc0", pc_out, 32);
    chk("rst_fv0", {31'b0, fetch_valid}, 0);
    tick();
    chk("rst_pc1", pc_out, 32);
    chk("rst_fv1", {31'b0, fetch_valid}, 0);
    chk("rst_ack", {31'b0, int_ack}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_saved", saved_pc, 0);
    reset = 1;
    #1;
    chk("run_addr32", imem_addr, 32);
    chk("run_fv32", {31'b0, fetch_valid}, 1);
    tick();
    chk("run_addr33", imem_addr, 33);
    chk("run_fv33", {31'b0, fetch_valid}, 1);
    tick();
    chk("run_addr34", imem_addr, 34);
    // stall at 40
    tick(6);
    chk("pc40", pc_out, 40);
    stall = 1;
    #1;
    chk("stall_fv", {31'b0, fetch_valid}, 0);
    tick();
    chk("stall_pc_a", pc_out, 40);
    tick();
    chk("stall_pc_b", pc_out, 40);
    tick();
    chk("stall_pc_c", pc_out, 40);
    stall = 0;
    #1;
    chk("unstall_fv", {31'b0, fetch_valid}, 1);
    tick();
    chk("unstall_pc", pc_out, 41);
    // branch overrides stall
    tick(4);
    chk("pc45", pc_out, 45);
    stall = 1; branch_taken = 1; branch_target = 32'h100;
    tick();
    chk("br_over_stall", pc_out, 32'h100);
    stall = 0; branch_target = 50;
    tick();
    chk("br_pc50", pc_out, 50);
    branch_taken = 0;
    // interrupt vector 3 -> handler 0x200
    int_req = 1; int_index = 3;
    #1;
    chk("int_addr50", imem_addr, 50);
    chk("int_take_fv", {31'b0, fetch_valid}, 0);
    tick();
    int_req = 0;
    chk("int_ack1", {31'b0, int_ack}, 1);
    chk("int_busy_hi", {31'b0, busy}, 1);
    chk("int_addr6", imem_addr, 6);
    chk("int_saved50", saved_pc, 50);
    chk("int_vhi_fv", {31'b0, fetch_valid}, 0);
    tick();
    chk("int_ack0", {31'b0, int_ack}, 0);
    chk("int_busy_lo", {31'b0, busy}, 1);
    chk("int_addr7", imem_addr, 7);
    tick();
    chk("int_busy_done", {31'b0, busy}, 0);
    chk("int_addr200", imem_addr, 32'h200);
    chk("int_fv_handler", {31'b0, fetch_valid}, 1);
    chk("int_ack_stays0", {31'b0, int_ack}, 0);
    int_done = 1;
    tick();
    int_done = 0;
    chk("done_no_pc_change", pc_out, 32'h201);
    // interrupt with concurrent branch keeps the branch as return address
    int_req = 1; branch_taken = 1; branch_target = 32'h80;
    tick();
    branch_taken = 0;
    chk("ib_ack", {31'b0, int_ack}, 1);
    chk("ib_saved80", saved_pc, 32'h80);
    tick(2);
    chk("ib_handler", pc_out, 32'h200);
    chk("ib_masked_fv", {31'b0, fetch_valid}, 1);
    tick();
    chk("ib_masked_busy", {31'b0, busy}, 0);
    chk("ib_masked_ack", {31'b0, int_ack}, 0);
    chk("ib_masked_pc", pc_out, 32'h201);
    int_done = 1;
    #1;
    chk("done_same_cycle_fv", {31'b0, fetch_valid}, 1);
    tick();
    int_done = 0;
    chk("done_same_cycle_busy", {31'b0, busy}, 0);
    chk("reaccept_fv", {31'b0, fetch_valid}, 0);
    tick();
    chk("reaccept_ack", {31'b0, int_ack}, 1);
    chk("reaccept_saved", saved_pc, 32'h202);
    tick();
    chk("vlo_addr7", imem_addr, 7);
    // reset in VEC_LO
    reset = 0;
    tick();
    reset = 1;
    #1;
    chk("rst_vlo_busy", {31'b0, busy}, 0);
    chk("rst_vlo_pc", pc_out, 32);
    chk("rst_vlo_inten_fv", {31'b0, fetch_valid}, 0);
    tick();
    int_req = 0;
    chk("rst_vlo_ack", {31'b0, int_ack}, 1);
    chk("rst_vlo_saved", saved_pc, 32);
    tick(2);
    chk("rst_vlo_handler", pc_out, 32'h200);
    // wrap at all-ones
    branch_taken = 1; branch_target = 32'hFFFF_FFFF;
    tick();
    branch_taken = 0;
    chk("pc_max", pc_out, 32'hFFFF_FFFF);
    tick();
    chk("pc_wrap", pc_out, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
